// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the Ethernet TX scheduler slice.
package eth_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SEND  = 3'd2,
        ST_GAP   = 3'd3,
        ST_ABORT = 3'd4
    } tx_sched_state_t;

    localparam int ETH_IFG_DEFAULT = 12;
    localparam int ETH_TX_MAX_REQ  = 8;
    localparam int REQ_ARP         = 0;
    localparam int REQ_UDP         = 1;

endpackage

// File: rtl/eth_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester after ptr_i, wrapping mod N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] elig_i,
    input  logic [2:0]   ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [2:0]   idx_o
);

    int          cand;
    logic [N-1:0] shifted;

    // Walk from the farthest candidate back to ptr+1 so the nearest one wins.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        cand    = 0;
        shifted = '0;
        for (int k = N; k >= 1; k--) begin
            cand    = (int'(ptr_i) + k) % N;
            shifted = elig_i >> cand;
            if (shifted[0]) begin
                gnt_o = N'(1) << cand;
                idx_o = 3'(cand);
            end
        end
    end

endmodule

// File: rtl/eth_tx_sched.sv
// Round-robin TX scheduler sharing one GMII byte stream between N_REQ senders.
// Optional hung-sender watchdog compiled in with ETH_TX_SCHED_WDOG_EN.
module eth_tx_sched
    import eth_tx_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int IFG_CYCLES = ETH_IFG_DEFAULT
`ifdef ETH_TX_SCHED_WDOG_EN
    ,
    parameter logic [31:0] WDOG_CYCLES = 32'd125000
`endif
) (
    input  logic               eth_tx_clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   i_req,
    output logic [N_REQ-1:0]   o_ack,
    output logic [N_REQ-1:0]   o_snd_en,
    input  logic [N_REQ-1:0]   i_snd_rdy,
    input  logic [8*N_REQ-1:0] i_snd_data,
    input  logic [N_REQ-1:0]   i_snd_tx_en,
    output logic [7:0]         eth_tx_data,
    output logic               eth_tx_data_en,
    output logic               o_busy,
    output logic [2:0]         o_grant,
    output logic [7:0]         o_err_cnt
);

    localparam int          GW       = $clog2(ETH_TX_MAX_REQ);
    localparam logic [GW-1:0] PTR_RST = GW'(N_REQ - 1);
    localparam logic [15:0] GAP_LAST = 16'(IFG_CYCLES - 1);

    tx_sched_state_t  state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d, ptr_q, ptr_d, arb_idx;
    logic [N_REQ-1:0] gnt_oh_q, gnt_oh_d, ack_q, ack_d, arb_gnt, eligible;
    logic [15:0]      gap_q, gap_d;
    logic [7:0]       data_q, data_d, data_sel;
    logic             den_q, den_d;
    logic             rdy_sel, tx_en_sel, tx_active;
`ifdef ETH_TX_SCHED_WDOG_EN
    logic [31:0]      wdog_q, wdog_d;
    logic [7:0]       err_q, err_d;
`endif

    assign eligible = i_req & i_snd_rdy;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .elig_i (eligible),
        .ptr_i  (ptr_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    // Only the granted sender's signals ever reach the mux outputs.
    assign rdy_sel   = |(i_snd_rdy & gnt_oh_q);
    assign tx_en_sel = |(i_snd_tx_en & gnt_oh_q);

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_oh_q[i]) data_sel = data_sel | i_snd_data[8*i +: 8];
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        gnt_oh_d = gnt_oh_q;
        ptr_d    = ptr_q;
        gap_d    = gap_q;
        ack_d    = '0;
        o_snd_en = '0;
`ifdef ETH_TX_SCHED_WDOG_EN
        wdog_d   = wdog_q;
        err_d    = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    state_d  = ST_START;
                    grant_d  = arb_idx;
                    gnt_oh_d = arb_gnt;
                    ptr_d    = arb_idx;
`ifdef ETH_TX_SCHED_WDOG_EN
                    wdog_d   = '0;
`endif
                end
            end
            // Enable is dropped in the same cycle the sender signals it has started.
            ST_START: begin
                if (rdy_sel) o_snd_en = gnt_oh_q;
                else         state_d  = ST_SEND;
            end
            ST_SEND: begin
                if (rdy_sel) begin
                    ack_d   = gnt_oh_q;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else                   gap_d   = gap_q + 16'd1;
            end
`ifdef ETH_TX_SCHED_WDOG_EN
            ST_ABORT: begin
                gap_d   = '0;
                state_d = ST_GAP;
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef ETH_TX_SCHED_WDOG_EN
        if (state_q == ST_START || state_q == ST_SEND) begin
            if (wdog_q == WDOG_CYCLES - 32'd1) begin
                state_d = ST_ABORT;
                ack_d   = '0;
            end else begin
                wdog_d = wdog_q + 32'd1;
            end
        end
`endif
        tx_active = (state_q == ST_START || state_q == ST_SEND) && (state_d != ST_ABORT);
        data_d    = tx_active ? data_sel : 8'h00;
        den_d     = tx_active & tx_en_sel;
    end

    always_ff @(posedge eth_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            gnt_oh_q <= '0;
            ptr_q    <= PTR_RST;
            gap_q    <= '0;
            ack_q    <= '0;
            data_q   <= '0;
            den_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            gnt_oh_q <= gnt_oh_d;
            ptr_q    <= ptr_d;
            gap_q    <= gap_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            den_q    <= den_d;
        end
    end

`ifdef ETH_TX_SCHED_WDOG_EN
    always_ff @(posedge eth_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= '0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
    assign o_err_cnt = err_q;
`else
    assign o_err_cnt = 8'h00;
`endif

    assign o_ack          = ack_q;
    assign eth_tx_data    = data_q;
    assign eth_tx_data_en = den_q;
    assign o_busy         = (state_q != ST_IDLE);
    assign o_grant        = grant_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched: behavioural senders, byte scoreboard, grant/ack logs.
`timescale 1ns/1ps
module tb_eth_tx_sched;

    localparam int N   = 4;
    localparam int IFG = 12;

    logic            eth_tx_clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    i_req;
    logic [N-1:0]    o_ack;
    logic [N-1:0]    o_snd_en;
    logic [N-1:0]    i_snd_rdy;
    logic [8*N-1:0]  i_snd_data;
    logic [N-1:0]    i_snd_tx_en;
    logic [7:0]      eth_tx_data;
    logic            eth_tx_data_en;
    logic            o_busy;
    logic [2:0]      o_grant;
    logic [7:0]      o_err_cnt;

    eth_tx_sched #(
        .N_REQ      (N),
        .IFG_CYCLES (IFG)
`ifdef ETH_TX_SCHED_WDOG_EN
        ,
        .WDOG_CYCLES(32'd100)
`endif
    ) dut (
        .eth_tx_clk     (eth_tx_clk),
        .rst_n          (rst_n),
        .i_req          (i_req),
        .o_ack          (o_ack),
        .o_snd_en       (o_snd_en),
        .i_snd_rdy      (i_snd_rdy),
        .i_snd_data     (i_snd_data),
        .i_snd_tx_en    (i_snd_tx_en),
        .eth_tx_data    (eth_tx_data),
        .eth_tx_data_en (eth_tx_data_en),
        .o_busy         (o_busy),
        .o_grant        (o_grant),
        .o_err_cnt      (o_err_cnt)
    );

    // ---------------- clock ----------------
    always #4 eth_tx_clk = ~eth_tx_clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- sender models ----------------
    int           s_len   [N];
    logic         s_block [N];
    logic         s_hang  [N];
    logic         s_act   [N];
    int           s_cnt   [N];
    logic [N-1:0] en_smp;
    int           cyc = 0;

    logic [7:0]   exp_q[$];
    int           exp_t_q[$];

    // Sample enable at the edge, drive the sender outputs 1 ns later.
    always @(posedge eth_tx_clk) begin
        cyc++;
        en_smp = o_snd_en;
        #1;
        for (int i = 0; i < N; i++) begin
            if (rst_n !== 1'b1) begin
                s_act[i] = 1'b0;
                s_cnt[i] = 0;
            end else if (!s_act[i] && en_smp[i]) begin
                s_act[i] = 1'b1;
                s_cnt[i] = 0;
            end
            if (s_act[i] && !s_hang[i] && s_cnt[i] < s_len[i]) begin
                i_snd_data[8*i +: 8] = 8'(i*64 + s_cnt[i]);
                i_snd_tx_en[i]       = 1'b1;
                i_snd_rdy[i]         = 1'b0;
                exp_q.push_back(8'(i*64 + s_cnt[i]));
                exp_t_q.push_back(cyc + 1);
                s_cnt[i]++;
            end else if (s_act[i] && !s_hang[i]) begin
                s_act[i]             = 1'b0;
                i_snd_rdy[i]         = 1'b1;
                i_snd_tx_en[i]       = 1'b0;
                i_snd_data[8*i +: 8] = 8'($urandom);
            end else if (s_act[i]) begin
                i_snd_rdy[i]         = 1'b0;
                i_snd_tx_en[i]       = 1'b0;
                i_snd_data[8*i +: 8] = 8'($urandom);
            end else begin
                i_snd_rdy[i]         = !s_block[i];
                i_snd_tx_en[i]       = 1'b0;
                i_snd_data[8*i +: 8] = 8'($urandom);
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int   ack_log[$], ack_cyc_log[$], grant_log[$], grant_cyc_log[$];
    int   en_width_log[$], gap_log[$];
    int   last_den = -1;
    int   nbytes   = 0;
    int   en_w     = 0;
    logic en_prev  = 1'b0;

    always @(negedge eth_tx_clk) begin
        if (rst_n !== 1'b1) begin
            en_prev = 1'b0;
        end else begin
            check_eq("snd_en_onehot0", 32'($onehot0(o_snd_en)), 32'd1);
            check_eq("ack_onehot0", 32'($onehot0(o_ack)), 32'd1);
            if (o_ack != '0) begin
                ack_log.push_back(oh_idx(o_ack));
                ack_cyc_log.push_back(cyc);
            end
            if (o_snd_en != '0 && !en_prev) begin
                grant_log.push_back(oh_idx(o_snd_en));
                grant_cyc_log.push_back(cyc);
                if (last_den >= 0) gap_log.push_back(cyc - last_den);
                en_w = 0;
            end
            if (o_snd_en != '0) en_w++;
            else if (en_prev)   en_width_log.push_back(en_w);
            en_prev = (o_snd_en != '0);
            if (eth_tx_data_en === 1'b1) begin
                nbytes++;
                last_den = cyc;
                if (exp_q.size() == 0) begin
                    check_eq("tx_spurious_byte", 32'(eth_tx_data_en), 32'd0);
                end else begin
                    check_eq("tx_byte", 32'(eth_tx_data), 32'(exp_q.pop_front()));
                    check_eq("tx_latency", 32'(cyc), 32'(exp_t_q.pop_front()));
                end
            end else if (exp_t_q.size() != 0 && exp_t_q[0] <= cyc) begin
                check_eq("tx_byte_missing", 32'(eth_tx_data_en), 32'd1);
                void'(exp_q.pop_front());
                void'(exp_t_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge eth_tx_clk);
        #1;
    endtask

    function automatic int count_of(input int what);
        case (what)
            0:       return ack_log.size();
            1:       return grant_log.size();
            2:       return nbytes;
            default: return (o_busy === 1'b0) ? 1 : 0;
        endcase
    endfunction

    task automatic wait_for(input int what, input int n, input int max_cyc, input string tag);
        int k = 0;
        while (count_of(what) < n && k < max_cyc) begin
            tick(1);
            k++;
        end
        if (count_of(what) < n) check_eq(tag, 32'(count_of(what)), 32'(n));
    endtask

    // Assert reset, check reset values asynchronously, clear logs, release.
    task automatic do_reset();
        rst_n = 1'b0;
        i_req = '0;
        #1;
        check_eq("rst_snd_en", 32'(o_snd_en), 32'd0);
        check_eq("rst_ack", 32'(o_ack), 32'd0);
        check_eq("rst_tx_data", 32'(eth_tx_data), 32'd0);
        check_eq("rst_tx_en", 32'(eth_tx_data_en), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_grant", 32'(o_grant), 32'd0);
        check_eq("rst_err_cnt", 32'(o_err_cnt), 32'd0);
        repeat (3) @(negedge eth_tx_clk);
        exp_q.delete();
        exp_t_q.delete();
        ack_log.delete();
        ack_cyc_log.delete();
        grant_log.delete();
        grant_cyc_log.delete();
        en_width_log.delete();
        gap_log.delete();
        last_den = -1;
        nbytes   = 0;
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n       = 1'b1;
        i_req       = '0;
        i_snd_rdy   = '1;
        i_snd_tx_en = '0;
        i_snd_data  = '0;
        for (int i = 0; i < N; i++) begin
            s_len[i]   = 20;
            s_block[i] = 1'b0;
            s_hang[i]  = 1'b0;
            s_act[i]   = 1'b0;
            s_cnt[i]   = 0;
        end
        #2;

        // Single request from requester 1, 64-byte packet.
        do_reset();
        for (int i = 0; i < N; i++) s_len[i] = 64;
        tick(2);
        i_req = 4'b0010;
        wait_for(0, 1, 300, "t1_ack_timeout");
        i_req = '0;
        tick(20);
        check_eq("t1_grant_cnt", 32'(grant_log.size()), 32'd1);
        check_eq("t1_grant_idx", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd1);
        check_eq("t1_ack_cnt", 32'(ack_log.size()), 32'd1);
        check_eq("t1_ack_idx", 32'(ack_log.size() > 0 ? ack_log[0] : -1), 32'd1);
        check_eq("t1_ack_after_last_byte",
                 32'(ack_cyc_log.size() > 0 ? ack_cyc_log[0] - last_den : -1), 32'd1);
        check_eq("t1_en_width", 32'(en_width_log.size() > 0 ? en_width_log[0] : -1), 32'd1);
        check_eq("t1_bytes", 32'(nbytes), 32'd64);
        check_eq("t1_o_grant", 32'(o_grant), 32'd1);
        check_eq("t1_idle", 32'(o_busy), 32'd0);
        check_eq("t1_sb_empty", 32'(exp_q.size()), 32'd0);

        // All four requesting continuously, 60-byte packets.
        do_reset();
        for (int i = 0; i < N; i++) s_len[i] = 60;
        i_req = 4'b1111;
        wait_for(0, 5, 1000, "t2_ack_timeout");
        i_req = '0;
        tick(20);
        for (int k = 0; k < 5; k++) begin
            check_eq($sformatf("t2_grant_order_%0d", k),
                     32'(grant_log.size() > k ? grant_log[k] : -1), 32'(k % 4));
        end
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("t2_gap_%0d", k),
                     32'(gap_log.size() > k ? gap_log[k] : -1), 32'(IFG + 2));
        end
        check_eq("t2_bytes", 32'(nbytes), 32'd300);
        check_eq("t2_sb_empty", 32'(exp_q.size()), 32'd0);

        // Requester 0 not ready: skipped, then served once ready.
        s_block[0] = 1'b1;
        do_reset();
        for (int i = 0; i < N; i++) s_len[i] = 20;
        i_req = 4'b0011;
        wait_for(1, 1, 50, "t3_grant_timeout");
        check_eq("t3_first_grant", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd1);
        s_block[0] = 1'b0;
        wait_for(0, 1, 200, "t3_ack1_timeout");
        i_req = 4'b0001;
        wait_for(0, 2, 200, "t3_ack2_timeout");
        i_req = '0;
        tick(20);
        check_eq("t3_second_grant", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'd0);
        check_eq("t3_ack0", 32'(ack_log.size() > 0 ? ack_log[0] : -1), 32'd1);
        check_eq("t3_ack1", 32'(ack_log.size() > 1 ? ack_log[1] : -1), 32'd0);

        // Requester 2 drops its request mid-packet.
        do_reset();
        i_req = 4'b0100;
        wait_for(2, 10, 100, "t4_bytes_timeout");
        i_req = '0;
        wait_for(0, 1, 200, "t4_ack_timeout");
        tick(40);
        check_eq("t4_ack_idx", 32'(ack_log.size() > 0 ? ack_log[0] : -1), 32'd2);
        check_eq("t4_ack_cnt", 32'(ack_log.size()), 32'd1);
        check_eq("t4_no_regrant", 32'(grant_log.size()), 32'd1);
        check_eq("t4_bytes", 32'(nbytes), 32'd20);

        // Reset at byte 30 of a packet from requester 0.
        do_reset();
        for (int i = 0; i < N; i++) s_len[i] = 64;
        i_req = 4'b0001;
        wait_for(2, 30, 100, "t5_bytes_timeout");
        check_eq("t5_no_ack_before_reset", 32'(ack_log.size()), 32'd0);
        do_reset();
        i_req = 4'b0011;
        wait_for(1, 1, 50, "t5_grant_timeout");
        check_eq("t5_grant_after_reset", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);
        check_eq("t5_no_stale_ack", 32'(ack_log.size()), 32'd0);
        i_req = '0;
        wait_for(0, 1, 200, "t5_ack_timeout");
        tick(20);
        check_eq("t5_ack_idx", 32'(ack_log.size() > 0 ? ack_log[0] : -1), 32'd0);

`ifdef ETH_TX_SCHED_WDOG_EN
        // Hung sender 0: watchdog abort after 100 cycles, then requester 1.
        s_hang[0] = 1'b1;
        do_reset();
        for (int i = 0; i < N; i++) s_len[i] = 20;
        i_req = 4'b0011;
        wait_for(1, 2, 400, "t6_grant_timeout");
        check_eq("t6_err_cnt", 32'(o_err_cnt), 32'd1);
        check_eq("t6_no_ack", 32'(ack_log.size()), 32'd0);
        check_eq("t6_next_grant", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'd1);
        check_eq("t6_abort_timing",
                 32'(grant_cyc_log.size() > 1 ? grant_cyc_log[1] - grant_cyc_log[0] : -1),
                 32'(100 + 1 + IFG + 1));
        i_req = '0;
        wait_for(0, 1, 200, "t6_ack_timeout");
        check_eq("t6_ack_idx", 32'(ack_log.size() > 0 ? ack_log[0] : -1), 32'd1);
        s_hang[0] = 1'b0;
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
